// File: rtl/mmio_rsp_merge_if.sv
// rtl/mmio_rsp_merge_if.sv - MMIO read-response merge bus (two sources in, registered c2 response out)
// Optional feature macro: MMIO_RSP_MERGE_DROP_CNT_EN adds drop_cnt[15:0].
interface mmio_rsp_merge_if #(
  parameter int DEPTH  = 8,
  parameter int TID_W  = 9,
  parameter int DATA_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              a_valid;
  logic [TID_W-1:0]  a_tid;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic [TID_W-1:0]  b_tid;
  logic [DATA_W-1:0] b_data;
  logic              clr_ovf;
  logic              out_valid;
  logic [TID_W-1:0]  out_tid;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
  logic              ovf;
`ifdef MMIO_RSP_MERGE_DROP_CNT_EN
  logic [15:0]       drop_cnt;

  modport master (
    output a_valid, a_tid, a_data, b_valid, b_tid, b_data, clr_ovf,
    input  out_valid, out_tid, out_data, count, ovf, drop_cnt
  );
  modport slave (
    input  a_valid, a_tid, a_data, b_valid, b_tid, b_data, clr_ovf,
    output out_valid, out_tid, out_data, count, ovf, drop_cnt
  );
`else
  modport master (
    output a_valid, a_tid, a_data, b_valid, b_tid, b_data, clr_ovf,
    input  out_valid, out_tid, out_data, count, ovf
  );
  modport slave (
    input  a_valid, a_tid, a_data, b_valid, b_tid, b_data, clr_ovf,
    output out_valid, out_tid, out_data, count, ovf
  );
`endif
endinterface

// File: rtl/mmio_rsp_merge.sv
// rtl/mmio_rsp_merge.sv - merges CSR (A) and user (B) MMIO read responses into one registered c2 stream
// Optional feature macro: MMIO_RSP_MERGE_DROP_CNT_EN adds a saturating dropped-B counter.
module mmio_rsp_merge #(
  parameter int DEPTH  = 8,
  parameter int TID_W  = 9,
  parameter int DATA_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  mmio_rsp_merge_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TID_W + DATA_W;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              out_valid_q;
  logic [TID_W-1:0]  out_tid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              ovf_q;

  logic              pop;
  logic              push_a;
  logic              push_b;
  logic              drop_b;
  logic [CW-1:0]     free_slots;
  logic [PW-1:0]     b_slot;

  // Pop whenever anything is queued; c2 never back-pressures. B yields to A when only one slot is free.
  always_comb begin
    pop        = 1'b0;
    push_a     = 1'b0;
    push_b     = 1'b0;
    drop_b     = 1'b0;
    free_slots = '0;
    b_slot     = wr_ptr;
    pop        = (count_q != '0);
    free_slots = CW'(DEPTH) - count_q + CW'(pop);
    push_a     = bus.a_valid;
    drop_b     = bus.a_valid && bus.b_valid && (free_slots < CW'(2));
    push_b     = bus.b_valid && !drop_b;
    b_slot     = bus.a_valid ? wr_ptr + PW'(1) : wr_ptr;
  end

  // Queue storage: A lands at wr_ptr, B right behind it (or at wr_ptr when alone).
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= {bus.a_tid, bus.a_data};
    if (push_b) mem[b_slot] <= {bus.b_tid, bus.b_data};
  end

  // Pointers, occupancy and registered output; tid/data hold their last value when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_tid_q   <= '0;
      out_data_q  <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push_a) + PW'(push_b);
      count_q <= count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
      if (pop) begin
        out_valid_q              <= 1'b1;
        {out_tid_q, out_data_q}  <= mem[rd_ptr];
        rd_ptr                   <= rd_ptr + PW'(1);
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ovf_q <= 1'b0;
    else if (drop_b)      ovf_q <= 1'b1;
    else if (bus.clr_ovf) ovf_q <= 1'b0;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_tid   = out_tid_q;
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;
  assign bus.ovf       = ovf_q;

`ifdef MMIO_RSP_MERGE_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped B responses; clear restarts at 1 if a drop coincides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 drop_cnt_q <= '0;
    else if (bus.clr_ovf)                    drop_cnt_q <= {15'd0, drop_b};
    else if (drop_b && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_mmio_rsp_merge.sv
// tb/tb_mmio_rsp_merge.sv - self-checking bench for mmio_rsp_merge with a queue-based reference model
module tb_mmio_rsp_merge;
  localparam int DEPTH  = 8;
  localparam int TID_W  = 9;
  localparam int DATA_W = 64;

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  bit   cmp_en;

  ent_t              mq[$];
  logic              m_valid;
  logic [TID_W-1:0]  m_tid;
  logic [DATA_W-1:0] m_data;
  logic              m_ovf;
  int                m_drops;

  mmio_rsp_merge_if #(.DEPTH(DEPTH), .TID_W(TID_W), .DATA_W(DATA_W)) bus ();

  mmio_rsp_merge #(.DEPTH(DEPTH), .TID_W(TID_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_valid = 1'b0;
    m_tid   = '0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // Reference: a plain FIFO of entries; one leaves per edge, then A and B enter if room remains.
  task automatic model_step();
    ent_t e;
    bit   drop;
    drop = 1'b0;
    if (mq.size() > 0) begin
      e       = mq.pop_front();
      m_valid = 1'b1;
      m_tid   = e.tid;
      m_data  = e.data;
    end else begin
      m_valid = 1'b0;
    end
    if (bus.a_valid) mq.push_back({bus.a_tid, bus.a_data});
    if (bus.b_valid) begin
      if (mq.size() < DEPTH) mq.push_back({bus.b_tid, bus.b_data});
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    if (bus.clr_ovf) m_drops = drop ? 1 : 0;
    else if (drop && m_drops < 16'hFFFF) m_drops++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else model_step();
    #2;
  endtask

  task automatic drive(input logic av, input logic [TID_W-1:0] at, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [TID_W-1:0] bt, input logic [DATA_W-1:0] bd,
                       input logic clr);
    bus.a_valid = av;
    bus.a_tid   = at;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_tid   = bt;
    bus.b_data  = bd;
    bus.clr_ovf = clr;
  endtask

  task automatic idle(input int n);
    drive(0, '0, '0, 0, '0, '0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Compare process: every falling edge the DUT outputs must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        chk("out_tid",   64'(bus.out_tid),   64'(m_tid));
        chk("out_data",  bus.out_data,       m_data);
        chk("count",     64'(bus.count),     64'(mq.size()));
        chk("ovf",       64'(bus.ovf),       64'(m_ovf));
`ifdef MMIO_RSP_MERGE_DROP_CNT_EN
        chk("drop_cnt",  64'(bus.drop_cnt),  64'(m_drops));
`endif
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cmp_en      = 1'b0;
    rst         = 1'b1;
    model_clear();
    drive(0, '0, '0, 0, '0, '0, 0);
    tick();
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();
    chk("reset_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_ovf",   64'(bus.ovf), 64'd0);
    chk("reset_tid",   64'(bus.out_tid), 64'd0);

    // Single A response: visible two edges later, exactly one cycle.
    drive(1, 9'h012, 64'hDEAD_BEEF, 0, '0, '0, 0);
    tick();
    drive(0, '0, '0, 0, '0, '0, 0);
    chk("single_n1_valid", 64'(bus.out_valid), 64'd0);
    chk("single_n1_count", 64'(bus.count), 64'd1);
    tick();
    chk("single_n2_valid", 64'(bus.out_valid), 64'd1);
    chk("single_n2_tid",   64'(bus.out_tid), 64'h012);
    chk("single_n2_data",  bus.out_data, 64'hDEAD_BEEF);
    chk("single_n2_count", 64'(bus.count), 64'd0);
    tick();
    chk("single_n3_valid", 64'(bus.out_valid), 64'd0);

    // Simultaneous A and B into an empty queue: A then B on consecutive cycles.
    drive(1, 9'd1, 64'd1, 1, 9'd2, 64'd2, 0);
    tick();
    drive(0, '0, '0, 0, '0, '0, 0);
    chk("both_count", 64'(bus.count), 64'd2);
    tick();
    chk("both_first_valid", 64'(bus.out_valid), 64'd1);
    chk("both_first_tid",   64'(bus.out_tid), 64'd1);
    tick();
    chk("both_second_valid", 64'(bus.out_valid), 64'd1);
    chk("both_second_tid",   64'(bus.out_tid), 64'd2);
    chk("both_ovf",          64'(bus.ovf), 64'd0);
    tick();
    chk("both_after_valid", 64'(bus.out_valid), 64'd0);

    // Continuous A+B: fills at edge 7, drops B from edge 8 through edge 20.
    for (int i = 0; i < 20; i++) begin
      drive(1, 9'(2 * i), 64'($urandom), 1, 9'(2 * i + 1), 64'($urandom), 0);
      tick();
    end
    chk("flood_count", 64'(bus.count), 64'd8);
    chk("flood_ovf",   64'(bus.ovf), 64'd1);
`ifdef MMIO_RSP_MERGE_DROP_CNT_EN
    chk("flood_drop_cnt", 64'(bus.drop_cnt), 64'd13);
`endif
    idle(12);

    // Clear with no drop, then a drop coinciding with a clear.
    drive(0, '0, '0, 0, '0, '0, 1);
    tick();
    chk("clr_ovf", 64'(bus.ovf), 64'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 9'(100 + 2 * i), 64'($urandom), 1, 9'(101 + 2 * i), 64'($urandom), 0);
      tick();
    end
    chk("refill_count", 64'(bus.count), 64'd8);
    chk("refill_ovf",   64'(bus.ovf), 64'd0);
    drive(1, 9'h1F0, 64'd7, 1, 9'h1F1, 64'd8, 1);
    tick();
    chk("clr_vs_drop_ovf", 64'(bus.ovf), 64'd1);
`ifdef MMIO_RSP_MERGE_DROP_CNT_EN
    chk("clr_vs_drop_cnt", 64'(bus.drop_cnt), 64'd1);
`endif
    idle(12);

    // Wrap-around: 20 A pushes with one idle cycle between them.
    for (int i = 0; i < 20; i++) begin
      drive(1, 9'(i), 64'(i) << 8, 0, '0, '0, 0);
      tick();
      idle(1);
    end
    idle(4);

    // Reset mid-operation with five entries queued.
    for (int i = 0; i < 4; i++) begin
      drive(1, 9'(200 + i), 64'($urandom), 1, 9'(300 + i), 64'($urandom), 0);
      tick();
    end
    drive(0, '0, '0, 0, '0, '0, 0);
    chk("prereset_count", 64'(bus.count), 64'd5);
    rst = 1'b1;
    model_clear();
    #1;
    chk("midreset_valid", 64'(bus.out_valid), 64'd0);
    chk("midreset_count", 64'(bus.count), 64'd0);
    chk("midreset_tid",   64'(bus.out_tid), 64'd0);
    chk("midreset_data",  bus.out_data, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("postreset_valid", 64'(bus.out_valid), 64'd0);
    end

    // Randomized traffic with varying densities.
    for (int i = 0; i < 800; i++) begin
      int dens;
      dens = (i / 100) % 4;
      drive(($urandom_range(3, 0) < dens + 1) ? 1'b1 : 1'b0, 9'($urandom), {$urandom, $urandom},
            ($urandom_range(3, 0) < dens) ? 1'b1 : 1'b0, 9'($urandom), {$urandom, $urandom},
            ($urandom_range(15, 0) == 0) ? 1'b1 : 1'b0);
      tick();
    end
    idle(12);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mmio_rsp_merge.md
# mmio_rsp_merge

Read-response merge queue between the AFU's MMIO read decoders and CCI-P Tx channel c2. It accepts MMIO read responses from two sources: port A is the single-cycle CSR/DFH decode path, port B is the multi-cycle user-logic path. It buffers them in one circular queue and emits at most one response per cycle as registered `mmioRdValid`/tid/data toward `tx.c2`. c2 has no back-pressure, so the block never stalls its output. Any overflow is reported, never hidden.

## Interface
Parameters:
- `DEPTH`, 8, queue entries; power of two, 2..64
- `TID_W`, 9, CCI-P MMIO transaction ID width
- `DATA_W`, 64, response data width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `a_valid`  in  1  CSR-path response present this cycle
- `a_tid`  in  TID_W  tid copied from the MMIO request header
- `a_data`  in  DATA_W  CSR read data
- `b_valid`  in  1  user-path response present this cycle
- `b_tid`  in  TID_W  tid for the B response
- `b_data`  in  DATA_W  user read data
- `clr_ovf`  in  1  clears `ovf` (synchronous pulse)
- `out_valid`  out  1  drives `tx.c2.mmioRdValid`
- `out_tid`  out  TID_W  drives `tx.c2.hdr.tid`
- `out_data`  out  DATA_W  drives `tx.c2.data`
- `count`  out  log2(DEPTH)+1  current occupancy
- `ovf`  out  1  sticky: a B response was dropped

## Operation
- Storage: DEPTH x (TID_W+DATA_W) array, `wr_ptr`/`rd_ptr` of log2(DEPTH) bits that wrap modulo DEPTH, plus `count` register.
- Pop: every cycle `count > 0` holds, entry `rd_ptr` is registered onto out_*; `out_valid` is set to 1 and `rd_ptr` is incremented. When `count == 0`, `out_valid` is set to 0. `out_tid` and `out_data` hold their last value.
- Free slots this cycle: `DEPTH - count + pop`. This is always at least 1 when `count == DEPTH`, because pop is then 1.
- Push order: A is written before B.
  - Both valid and free ≥ 2: A goes to `wr_ptr` and B goes to `wr_ptr+1`; `wr_ptr` advances by 2.
  - Both valid and free == 1: A is written and B is dropped.
  - Single valid: that response is written.
- A is never dropped.
- Next `count` is `count + pushes - pop`.
- `ovf` sets on any dropped B. It clears on `clr_ovf`. If a set and a clear happen in the same cycle, set wins.
- A and B carrying the same tid is legal; no tid checking is performed.

## Timing
- Reset: `out_valid` = 0, `out_tid` = 0, `out_data` = 0, `count` = 0, `ovf` = 0, pointers = 0. Reset mid-operation discards all queued entries; no response is emitted after reset deasserts.
- Latency with the queue empty: response presented in cycle N gives `out_valid` high in cycle N+2. Push at edge N+1, pop/register at edge N+2.
- Throughput: 1 response/cycle out, 2 responses/cycle in.
- `out_valid` is high for exactly one cycle per accepted entry. Back-to-back entries give consecutive high cycles.
- Output order matches push order, A before B within a cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MMIO_RSP_MERGE_DROP_CNT_EN`
  - Defined: adds output `drop_cnt` [15:0], which counts dropped B responses. It saturates at 16'hFFFF, is cleared by `clr_ovf` (a drop in the same cycle leaves it at 1), and resets to 0.
  - Undefined: the port and counter do not exist; only sticky `ovf` reports overflow.

## Test plan
- Single A: tid 9'h012, data 64'hDEAD_BEEF in cycle 5 → `out_valid` high only in cycle 7 with tid 9'h012, data 64'hDEAD_BEEF; `count` returns to 0.
- Simultaneous A (tid 1, data 1) and B (tid 2, data 2) in an empty queue → two consecutive `out_valid` cycles, tid 1 then tid 2; `ovf` stays 0.
- Continuous A+B every cycle with DEPTH=8 → `count` reaches 8 and stays there; later B responses are dropped and `ovf` = 1; all A tids come out in order; with the macro defined, `drop_cnt` equals the number of missing B tids.
- `clr_ovf` pulse with no further drops → `ovf` = 0 next cycle; a drop coinciding with `clr_ovf` → `ovf` = 1.
- Wrap-around: 20 single A pushes spaced 1 cycle apart, tids 0..19 → outputs tids 0..19 in order; pointers wrap with no loss.
- Assert `rst` for 1 cycle with `count` = 5 → all outputs 0 at once; after release, `out_valid` stays 0 until a new push.
